// File: rtl/load_queue_pkg.sv
// Shared definitions for the load queue: widths, boolean constants and the entry layout.
package load_queue_pkg;

    localparam int XLEN        = 32;
    localparam int ROB_TAG_LEN = 5;
    localparam int LQ_DEPTH    = 4;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef struct packed {
        logic                   valid;
        logic                   speculative;
        logic [XLEN-1:0]        address;
        logic [ROB_TAG_LEN-1:0] rd_tag;
    } lq_entry_t;

endpackage

// File: rtl/load_queue_spec_finder.sv
// Kill helper: finds the oldest speculative entry (walking from head) and counts
// the valid non-speculative entries that survive a squash.
module lq_spec_finder #(
    parameter int LQ_DEPTH = 4
) (
    input  logic [LQ_DEPTH-1:0]         valid,
    input  logic [LQ_DEPTH-1:0]         speculative,
    input  logic [$clog2(LQ_DEPTH)-1:0] head,
    output logic                        has_spec,
    output logic [$clog2(LQ_DEPTH)-1:0] oldest_spec,
    output logic [$clog2(LQ_DEPTH):0]   nonspec_count
);
    import load_queue_pkg::*;

    localparam int PW = $clog2(LQ_DEPTH);

    logic [PW-1:0] idx;

    always_comb begin
        has_spec      = FALSE;
        oldest_spec   = head;
        nonspec_count = '0;
        idx           = head;
        for (int k = 0; k < LQ_DEPTH; k++) begin
            idx = head + PW'(k);
            if (valid[idx] && speculative[idx] && !has_spec) begin
                has_spec    = TRUE;
                oldest_spec = idx;
            end
            if (valid[idx] && !speculative[idx])
                nonspec_count = nonspec_count + 1'b1;
        end
    end

endmodule

// File: rtl/load_queue.sv
// In-order load queue between the ACU and the data-memory port, with
// single-level speculation tracking and selective squash on branch kill.
module load_queue #(
    parameter int LQ_DEPTH    = load_queue_pkg::LQ_DEPTH,
    parameter int XLEN        = load_queue_pkg::XLEN,
    parameter int ROB_TAG_LEN = load_queue_pkg::ROB_TAG_LEN
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        alloc_valid,
    input  logic [XLEN-1:0]             alloc_address,
    input  logic [ROB_TAG_LEN-1:0]      alloc_rd_tag,
    input  logic                        alloc_speculative,
    output logic                        alloc_ready,
    input  logic                        pending_stores,
    input  logic                        issue_stall,
    input  logic                        kill,
    input  logic                        resolve,
    output logic                        read_mem,
    output logic [XLEN-1:0]             load_address,
    output logic [ROB_TAG_LEN-1:0]      load_rob_tag,
    output logic                        load_speculative,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(LQ_DEPTH):0]   count
);
    import load_queue_pkg::*;

    localparam int PW = $clog2(LQ_DEPTH);
    localparam int CW = PW + 1;

    logic [LQ_DEPTH-1:0]    valid_q;
    logic [LQ_DEPTH-1:0]    spec_q;
    logic [XLEN-1:0]        addr_q [LQ_DEPTH];
    logic [ROB_TAG_LEN-1:0] tag_q  [LQ_DEPTH];
    logic [PW-1:0]          head, tail, tail_w, oldest_spec;
    logic                   has_spec, head_valid, head_spec, alloc_fire, retire;
    logic [CW-1:0]          nonspec_count, count_next;

    lq_spec_finder #(.LQ_DEPTH(LQ_DEPTH)) u_spec_finder (
        .valid         (valid_q),
        .speculative   (spec_q),
        .head          (head),
        .has_spec      (has_spec),
        .oldest_spec   (oldest_spec),
        .nonspec_count (nonspec_count)
    );

    assign head_valid = valid_q[head];
    assign head_spec  = spec_q[head];

    // Registered full gates allocation, so a same-cycle retire never frees a slot early.
    assign alloc_ready = !full;
    assign alloc_fire  = alloc_valid && alloc_ready && !(kill && alloc_speculative);
    assign read_mem    = head_valid && !pending_stores && !(kill && head_spec);
    assign retire      = read_mem && !issue_stall;

    assign load_address     = head_valid ? addr_q[head] : '0;
    assign load_rob_tag     = head_valid ? tag_q[head]  : '0;
    assign load_speculative = head_valid && head_spec;

    // Speculative entries form the youngest suffix, so kill rewinds tail to its start.
    assign tail_w = (kill && has_spec) ? oldest_spec : tail;

    always_comb begin
        count_next = kill ? nonspec_count : count;
        count_next = count_next + CW'(alloc_fire) - CW'(retire);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
            spec_q  <= '0;
            for (int i = 0; i < LQ_DEPTH; i++) begin
                addr_q[i] <= '0;
                tag_q[i]  <= '0;
            end
            head  <= '0;
            tail  <= '0;
            count <= '0;
            full  <= FALSE;
            empty <= TRUE;
        end else begin
            for (int i = 0; i < LQ_DEPTH; i++) begin
                if (kill && spec_q[i]) begin
                    valid_q[i] <= FALSE;
                    spec_q[i]  <= FALSE;
                end else if (resolve) begin
                    spec_q[i] <= FALSE;
                end
            end
            if (retire) begin
                valid_q[head] <= FALSE;
                head          <= head + 1'b1;
            end
            if (alloc_fire) begin
                valid_q[tail_w] <= TRUE;
                spec_q[tail_w]  <= alloc_speculative && !resolve;
                addr_q[tail_w]  <= alloc_address;
                tag_q[tail_w]   <= alloc_rd_tag;
                tail            <= tail_w + 1'b1;
            end else begin
                tail <= tail_w;
            end
            count <= count_next;
            full  <= (count_next == CW'(LQ_DEPTH));
            empty <= (count_next == '0);
        end
    end

endmodule

// File: doc/load_queue.md
Name: load_queue

Overview:
- Multi-entry, in-order load queue between the address calculation unit (ACU) and the data-memory port.
- Successor to the single-entry load buffer: parametrised depth, FIFO age ordering, per-entry speculation tracking, selective squash on branch kill.
- Issues the oldest load to memory only when the ROB reports no older pending stores.
- Publishes the issuing load's address and ROB tag to the ROB.

Parameters:
- LQ_DEPTH, 4: number of entries; power of two, ≥2.
- XLEN, 32: address width.
- ROB_TAG_LEN, 5: ROB tag width.

Ports:
- clock  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- alloc_valid  in  1  ACU presents a load this cycle.
- alloc_address  in  XLEN  effective address.
- alloc_rd_tag  in  ROB_TAG_LEN  ROB tag of the load.
- alloc_speculative  in  1  load is under an unresolved branch.
- alloc_ready  out  1  queue accepts allocation (= !full).
- pending_stores  in  1  from ROB; older stores not yet committed.
- issue_stall  in  1  from hazard unit; memory port busy.
- kill  in  1  branch mispredict; squash speculative entries.
- resolve  in  1  branch resolved correctly; clear speculative bits.
- read_mem  out  1  head load issuing to memory this cycle.
- load_address  out  XLEN  head entry address.
- load_rob_tag  out  ROB_TAG_LEN  head entry tag.
- load_speculative  out  1  head entry speculative bit.
- full  out  1  count == LQ_DEPTH (registered).
- empty  out  1  count == 0 (registered).
- count  out  $clog2(LQ_DEPTH)+1  occupied entries.

Behaviour:
- Storage:
  - Circular array of entries {valid, speculative, address, rd_tag}.
  - head/tail pointers of $clog2(LQ_DEPTH) bits wrap naturally; a registered count disambiguates full/empty.
- Reset:
  - All entries invalid; head = tail = 0; count = 0; full = 0; empty = 1.
  - read_mem = 0; load_address, load_rob_tag and load_speculative read 0.
  - Reset mid-operation discards all entries without issuing.
- Allocate:
  - Occurs when alloc_valid && alloc_ready && !(kill && alloc_speculative).
  - Entry is written at tail and tail increments.
  - The stored speculative bit is alloc_speculative && !resolve.
  - alloc_ready uses registered full: a full queue refuses allocation even if an issue frees an entry in the same cycle.
- Issue (combinational request, registered retire):
  - read_mem = head.valid && !pending_stores && !(kill && head.speculative).
  - The entry retires (head++, entry invalidated) at the clock edge where read_mem && !issue_stall.
  - Under stall, outputs hold steady; no retire occurs.
- Ordering:
  - Only the head may issue; no bypassing of younger loads.
  - The issue latency of an unblocked load is at minimum one cycle after allocation; there is no same-cycle allocate-and-issue from an empty queue.
- Kill:
  - Speculative entries are always a contiguous youngest suffix, because a single branch level is tracked.
  - On kill, every entry with speculative=1 is invalidated.
  - tail is set to the oldest speculative index, or unchanged if there are none.
  - count is recomputed as (retire-adjusted) non-speculative count.
  - A non-speculative allocation in the same cycle lands at the new tail.
  - A head retire in the same cycle is honoured only if the head is non-speculative.
- Resolve:
  - All speculative bits are cleared at the edge.
  - kill and resolve asserted together is illegal; the bench asserts it, and RTL gives kill priority.
- Counts:
  - count_next = count + alloc_fire − retire_fire, or the recomputed value on kill.
  - full and empty are registered from count_next.
- Both pointer wraps (LQ_DEPTH−1 → 0) must be exercised.

Decomposition:
- Shared package gains the LQ_ENTRY typedef {valid, speculative, address[XLEN], rd_tag[ROB_TAG_LEN]} and the LQ_DEPTH default.
- Existing XLEN, ROB_TAG_LEN, TRUE and FALSE are reused.
- One sub-module is natural: lq_spec_finder, a combinational priority encoder that returns the oldest speculative index relative to head, plus the count of non-speculative entries, for kill handling.
- The rest stays in load_queue.

Test Plan:
- Fill with 4 non-spec loads (tags 1–4, addr 0x100–0x10C), pending_stores=0, issue_stall=0 → read_mem each cycle; tags issue 1,2,3,4; full rises after 4th alloc while issue lags; empty=1 at end.
- Queue full (4 entries), alloc_valid=1 with concurrent retire → alloc_ready=0 that cycle; the load is accepted next cycle; count stays ≤4.
- Entries tags 5,6 non-spec plus 7,8 spec; pulse kill → tags 7,8 squashed; count=2; tail points after tag 6; subsequent non-spec alloc tag 9 issues after 6.
- Head tag 3, pending_stores=1 for 3 cycles, then issue_stall=1 for 2 cycles → read_mem=0 for 3 cycles, then read_mem=1 held with address stable 2 cycles; retire on the 6th cycle.
- Spec entries tags 10,11; resolve pulse, then kill next cycle → both survive and issue (load_speculative=0).
- Run 10 alloc/retire cycles with LQ_DEPTH=4 → head/tail wrap twice; issue order preserved; assert reset mid-stream clears count to 0 and read_mem to 0 next cycle.
